chan_cfg_scaler: RTL and testbench

Parametrised successor of the per-channel timing RAM. It holds byte-addressed channel records written from the UART Rx path. It converts each record's 16-bit duration and delay values, plus their unit codes, into tick counts using a sequential shift-add multiplier, and drives packed PL_drt / DL_del / type_start vectors to the pulse channels. Only records that have changed are recomputed. Results saturate instead of wrapping, and readback is supported.

---
 rtl/chan_cfg_scaler.sv | 263 ++++++++++++++++++++++++++
 tb/tb_chan_cfg_scaler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_cfg_scaler.sv
// chan_cfg_scaler: per-channel timing records scaled to tick counts by a serial shift-add multiplier.
// Optional: define CFG_SEC_UNIT_EN to accept unit code 4 (seconds, x S_MULT).
module chan_cfg_scaler #(
   parameter int unsigned N_CH    = 16,
   parameter int unsigned AW      = 8,
   parameter int unsigned OUT_W   = 35,
   parameter int unsigned US_MULT = 100,
   parameter int unsigned MS_MULT = 100000,
   parameter int unsigned S_MULT  = 100000000,
   localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                    clk_RAM,
   input  logic                    rst_RAM,
   input  logic [7:0]              in,
   input  logic [AW-1:0]           w_addr,
   input  logic                    write,
   input  logic [AW-1:0]           rd_addr,
   output logic [7:0]              rd_data,
   output logic [N_CH*OUT_W-1:0]   PL_drt,
   output logic [N_CH*OUT_W-1:0]   DL_del,
   output logic [N_CH-1:0]         type_start,
   output logic [N_CH-1:0]         ovf,
   output logic                    busy,
   output logic                    upd_stb,
   output logic [CH_W-1:0]         upd_ch
);

   localparam int unsigned MEM_N = 7 * N_CH;
   localparam int unsigned ACC_W = OUT_W + 11;

   if ((2 ** AW) < MEM_N || ACC_W < 16 + $clog2(S_MULT + 1)) begin : g_cfg_check
      $error("chan_cfg_scaler: AW or OUT_W too small for the configuration");
   end

   typedef enum logic [2:0] {IDLE, LOAD, MUL_D, MUL_L, COMMIT} state_t;
   state_t state_q, state_d;

   logic [7:0]             mem_q [MEM_N];
   logic [7:0]             mem_d [MEM_N];
   logic [N_CH-1:0]        dirty_q, dirty_d;
   logic [CH_W-1:0]        sel_q, sel_d, ptr_q, ptr_d;
   logic                   snap_ts_q, snap_ts_d;
   logic [7:0]             snap_lu_q, snap_lu_d;
   logic [15:0]            snap_lv_q, snap_lv_d;
   logic                   du_ok_q, du_ok_d, dl_ok_q, dl_ok_d;
   logic [ACC_W-1:0]       mcand_q, mcand_d, acc_q, acc_d, dur_res_q, dur_res_d;
   logic [15:0]            mplier_q, mplier_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [N_CH*OUT_W-1:0]  pl_q, pl_d, dl_q, dl_d;
   logic [N_CH-1:0]        ts_q, ts_d, ovf_q, ovf_d;
   logic                   upd_stb_q, upd_stb_d;
   logic [CH_W-1:0]        upd_ch_q, upd_ch_d;
   logic [7:0]             rd_data_q, rd_data_d;

   logic                   found;
   logic [CH_W-1:0]        pick;
   logic [N_CH-1:0]        rot;
   logic [CH_W:0]          rr_sum;
   logic [ACC_W:0]         f_unit;
   logic [ACC_W-1:0]       sum_acc;
   logic                   dur_sat, del_sat;

   // MSB is the valid flag; invalid codes leave the target output untouched.
   function automatic logic [ACC_W:0] unit_factor(input logic [7:0] u);
      logic [ACC_W:0] r;
      r = '0;
      case (u)
         8'd1: r = {1'b1, ACC_W'(1)};
         8'd2: r = {1'b1, ACC_W'(US_MULT)};
         8'd3: r = {1'b1, ACC_W'(MS_MULT)};
`ifdef CFG_SEC_UNIT_EN
         8'd4: r = {1'b1, ACC_W'(S_MULT)};
`endif
         default: r = '0;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk_RAM or posedge rst_RAM) begin
      if (rst_RAM) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|dirty_q) state_d = LOAD;
         LOAD:    state_d = MUL_D;
         MUL_D:   if (cnt_q == '1) state_d = MUL_L;
         MUL_L:   if (cnt_q == '1) state_d = COMMIT;
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != IDLE);
   end

   // Round-robin: rotate dirty so the pointer sits at bit 0, take the first set bit.
   always_comb begin
      found  = 1'b0;
      pick   = '0;
      rr_sum = '0;
      rot    = N_CH'({dirty_q, dirty_q} >> ptr_q);
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (!found && rot[i]) begin
            found  = 1'b1;
            rr_sum = {1'b0, ptr_q} + (CH_W+1)'(i);
            if (rr_sum >= (CH_W+1)'(N_CH)) rr_sum = rr_sum - (CH_W+1)'(N_CH);
            pick   = rr_sum[CH_W-1:0];
         end
      end
   end

   always_comb begin
      rd_data_d = '0;
      for (int unsigned i = 0; i < MEM_N; i++) begin
         if (rd_addr == AW'(i)) rd_data_d = mem_q[i];
      end
   end

   always_comb begin
      mem_d      = mem_q;
      dirty_d    = dirty_q;
      sel_d      = sel_q;
      ptr_d      = ptr_q;
      snap_ts_d  = snap_ts_q;
      snap_lu_d  = snap_lu_q;
      snap_lv_d  = snap_lv_q;
      du_ok_d    = du_ok_q;
      dl_ok_d    = dl_ok_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      dur_res_d  = dur_res_q;
      pl_d       = pl_q;
      dl_d       = dl_q;
      ts_d       = ts_q;
      ovf_d      = ovf_q;
      upd_stb_d  = 1'b0;
      upd_ch_d   = upd_ch_q;
      f_unit     = '0;
      sum_acc    = acc_q + (mplier_q[0] ? mcand_q : '0);
      dur_sat    = |dur_res_q[ACC_W-1:OUT_W];
      del_sat    = |acc_q[ACC_W-1:OUT_W];

      // Clear before the write loop so a same-cycle write re-dirties the channel.
      if (state_q == LOAD) dirty_d[sel_q] = 1'b0;
      for (int unsigned i = 0; i < MEM_N; i++) begin
         if (!write && w_addr == AW'(i)) begin
            mem_d[i]               = in;
            dirty_d[N_CH-1-i/7]    = 1'b1;
         end
      end

      case (state_q)
         IDLE: if (found) sel_d = pick;
         LOAD: begin
            for (int unsigned c = 0; c < N_CH; c++) begin
               if (sel_q == CH_W'(c)) begin
                  snap_ts_d = mem_q[7*(N_CH-1-c)][0];
                  snap_lu_d = mem_q[7*(N_CH-1-c)+1];
                  snap_lv_d = {mem_q[7*(N_CH-1-c)+2], mem_q[7*(N_CH-1-c)+3]};
                  f_unit    = unit_factor(mem_q[7*(N_CH-1-c)+4]);
                  du_ok_d   = f_unit[ACC_W];
                  mcand_d   = f_unit[ACC_W-1:0];
                  mplier_d  = {mem_q[7*(N_CH-1-c)+5], mem_q[7*(N_CH-1-c)+6]};
               end
            end
            acc_d = '0;
            cnt_d = '0;
         end
         MUL_D, MUL_L: begin
            acc_d    = sum_acc;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (state_q == MUL_D && cnt_q == '1) begin
               dur_res_d = sum_acc;
               f_unit    = unit_factor(snap_lu_q);
               dl_ok_d   = f_unit[ACC_W];
               mcand_d   = f_unit[ACC_W-1:0];
               mplier_d  = snap_lv_q;
               acc_d     = '0;
            end
         end
         COMMIT: begin
            for (int unsigned c = 0; c < N_CH; c++) begin
               if (sel_q == CH_W'(c)) begin
                  if (du_ok_q) pl_d[c*OUT_W +: OUT_W] = dur_sat ? '1 : dur_res_q[OUT_W-1:0];
                  if (dl_ok_q) dl_d[c*OUT_W +: OUT_W] = del_sat ? '1 : acc_q[OUT_W-1:0];
                  ts_d[c] = snap_ts_q;
                  if ((du_ok_q && dur_sat) || (dl_ok_q && del_sat)) ovf_d[c] = 1'b1;
                  else if (du_ok_q && dl_ok_q)                      ovf_d[c] = 1'b0;
               end
            end
            ptr_d     = (sel_q == CH_W'(N_CH-1)) ? '0 : sel_q + 1'b1;
            upd_stb_d = 1'b1;
            upd_ch_d  = sel_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_RAM or posedge rst_RAM) begin
      if (rst_RAM) begin
         mem_q     <= '{default: '0};
         dirty_q   <= '0;
         sel_q     <= '0;
         ptr_q     <= '0;
         snap_ts_q <= 1'b0;
         snap_lu_q <= '0;
         snap_lv_q <= '0;
         du_ok_q   <= 1'b0;
         dl_ok_q   <= 1'b0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         dur_res_q <= '0;
         pl_q      <= '0;
         dl_q      <= '0;
         ts_q      <= '0;
         ovf_q     <= '0;
         upd_stb_q <= 1'b0;
         upd_ch_q  <= '0;
         rd_data_q <= '0;
      end else begin
         mem_q     <= mem_d;
         dirty_q   <= dirty_d;
         sel_q     <= sel_d;
         ptr_q     <= ptr_d;
         snap_ts_q <= snap_ts_d;
         snap_lu_q <= snap_lu_d;
         snap_lv_q <= snap_lv_d;
         du_ok_q   <= du_ok_d;
         dl_ok_q   <= dl_ok_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         dur_res_q <= dur_res_d;
         pl_q      <= pl_d;
         dl_q      <= dl_d;
         ts_q      <= ts_d;
         ovf_q     <= ovf_d;
         upd_stb_q <= upd_stb_d;
         upd_ch_q  <= upd_ch_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data    = rd_data_q;
   assign PL_drt     = pl_q;
   assign DL_del     = dl_q;
   assign type_start = ts_q;
   assign ovf        = ovf_q;
   assign upd_stb    = upd_stb_q;
   assign upd_ch     = upd_ch_q;

endmodule

// File: tb/tb_chan_cfg_scaler.sv
// Directed bench for chan_cfg_scaler: default build (OUT_W=35) plus an OUT_W=32 instance for saturation.
module tb_chan_cfg_scaler;

   logic          clk = 1'b0;
   logic          rst;
   logic          write;
   logic [7:0]    din, w_addr, rd_addr;

   logic [7:0]       rd35, rd32;
   logic [16*35-1:0] PL35, DL35;
   logic [16*32-1:0] PL32, DL32;
   logic [15:0]      ts35, ts32, ovf35, ovf32;
   logic             busy35, busy32, stb35, stb32;
   logic [3:0]       ch35, ch32;

   int errors = 0, checks = 0;
   int n_commit = 0, n_commit32 = 0, last_ch = -1, last_ch32 = -1;
   bit fair_armed = 1'b0;
   int fair_base = 0, fair_ord = 0;

   typedef struct {
      int     ch;
      longint pl, dl;
      bit     ts, ovf;
      longint pl32;
      bit     ovf32;
   } exp_t;
   exp_t sbq[$];

   always #5 clk = ~clk;

   chan_cfg_scaler dut35 (
      .clk_RAM(clk), .rst_RAM(rst), .in(din), .w_addr(w_addr), .write(write),
      .rd_addr(rd_addr), .rd_data(rd35), .PL_drt(PL35), .DL_del(DL35),
      .type_start(ts35), .ovf(ovf35), .busy(busy35), .upd_stb(stb35), .upd_ch(ch35));

   chan_cfg_scaler #(.OUT_W(32)) dut32 (
      .clk_RAM(clk), .rst_RAM(rst), .in(din), .w_addr(w_addr), .write(write),
      .rd_addr(rd_addr), .rd_data(rd32), .PL_drt(PL32), .DL_del(DL32),
      .type_start(ts32), .ovf(ovf32), .busy(busy32), .upd_stb(stb32), .upd_ch(ch32));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (stb35 === 1'b1) begin
         n_commit++;
         last_ch = int'(ch35);
         if (fair_armed && ch35 == 4'd0 && fair_ord == 0) fair_ord = n_commit - fair_base;
      end
      if (stb32 === 1'b1) begin
         n_commit32++;
         last_ch32 = int'(ch32);
      end
   end

   task automatic wr(input int a, input logic [7:0] d);
      @(negedge clk);
      w_addr = 8'(a);
      din    = d;
      write  = 1'b0;
   endtask

   task automatic wr_done();
      @(negedge clk);
      write = 1'b1;
   endtask

   task automatic wr_rec(input int ch, input logic [7:0] ty, input logic [7:0] lu,
                         input logic [15:0] lv, input logic [7:0] du, input logic [15:0] dv);
      int b;
      b = 7 * (15 - ch);
      wr(b, ty); wr(b+1, lu); wr(b+2, lv[15:8]); wr(b+3, lv[7:0]);
      wr(b+4, du); wr(b+5, dv[15:8]); wr(b+6, dv[7:0]);
      wr_done();
   endtask

   task automatic push(input int ch, input longint pl, input longint dl, input bit ts,
                       input bit ov, input longint pl32, input bit ov32);
      exp_t e;
      e.ch = ch; e.pl = pl; e.dl = dl; e.ts = ts; e.ovf = ov; e.pl32 = pl32; e.ovf32 = ov32;
      sbq.push_back(e);
   endtask

   // Quiescent once busy has stayed low for several cycles (a pending dirty bit keeps IDLE for one cycle only).
   task automatic settle(input string tag);
      int idle, k;
      idle = 0; k = 0;
      while (idle < 4 && k < 3000) begin
         @(negedge clk);
         k++;
         if (busy35 === 1'b0) idle++;
         else                 idle = 0;
      end
      chk({tag, "_settle"}, 64'(idle >= 4), 64'd1);
   endtask

   task automatic check_sb();
      exp_t e;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk($sformatf("pl35_ch%0d", e.ch),  64'(PL35[e.ch*35 +: 35]), 64'(e.pl));
         chk($sformatf("dl35_ch%0d", e.ch),  64'(DL35[e.ch*35 +: 35]), 64'(e.dl));
         chk($sformatf("ts35_ch%0d", e.ch),  64'(ts35[e.ch]),          64'(e.ts));
         chk($sformatf("ovf35_ch%0d", e.ch), 64'(ovf35[e.ch]),         64'(e.ovf));
         chk($sformatf("pl32_ch%0d", e.ch),  64'(PL32[e.ch*32 +: 32]), 64'(e.pl32));
         chk($sformatf("dl32_ch%0d", e.ch),  64'(DL32[e.ch*32 +: 32]), 64'(e.dl));
         chk($sformatf("ts32_ch%0d", e.ch),  64'(ts32[e.ch]),          64'(e.ts));
         chk($sformatf("ovf32_ch%0d", e.ch), 64'(ovf32[e.ch]),         64'(e.ovf32));
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "global timeout");
   end

   initial begin
      int n0, n0_32, first_k, busy_k2;
      logic [7:0] fin [7];
      longint sec_exp;
      fin = '{8'd1, 8'd2, 8'h00, 8'h10, 8'd1, 8'h12, 8'h34};

      rst = 1'b1; write = 1'b1; din = '0; w_addr = '0; rd_addr = '0;
      repeat (2) @(negedge clk);
      chk("rst_pl",   64'(PL35 == '0), 64'd1);
      chk("rst_dl",   64'(DL35 == '0), 64'd1);
      chk("rst_ts",   64'(ts35), 64'd0);
      chk("rst_ovf",  64'(ovf35), 64'd0);
      chk("rst_busy", 64'(busy35), 64'd0);
      chk("rst_stb",  64'(stb35), 64'd0);
      chk("rst_rd",   64'(rd35), 64'd0);
      rst = 1'b0;

      // ch1 record: dur 100 x1, delay 5 x US_MULT
      push(0, 100, 500, 1'b1, 1'b0, 100, 1'b0);
      wr_rec(0, 8'd1, 8'd2, 16'h0005, 8'd1, 16'h0064);
      settle("ch0");
      check_sb();
      chk("ch0_last_upd", 64'(last_ch), 64'd0);

      rd_addr = 8'd111; @(negedge clk);
      chk("rd_111", 64'(rd35), 64'h64);
      chk("rd32_111", 64'(rd32), 64'h64);
      rd_addr = 8'd106; @(negedge clk);
      chk("rd_106", 64'(rd35), 64'h02);
      rd_addr = 8'd200; @(negedge clk);
      chk("rd_oor", 64'(rd35), 64'd0);

      n0 = n_commit;
      wr(112, 8'hAA); wr_done();
      repeat (40) @(negedge clk);
      chk("oor_write_commits", 64'(n_commit - n0), 64'd0);
      rd_addr = 8'd112; @(negedge clk);
      chk("rd_112", 64'(rd35), 64'd0);

      // Single-byte rewrite: commit must land exactly 35 cycles after the write edge
      n0 = n_commit; n0_32 = n_commit32; first_k = 0; busy_k2 = 0;
      push(0, 100, 500, 1'b0, 1'b0, 100, 1'b0);
      wr(105, 8'h00);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) write = 1'b1;
         if (k == 2) busy_k2 = int'(busy35);
         if (stb35 === 1'b1 && first_k == 0) first_k = k;
      end
      chk("latency", 64'(first_k - 1), 64'd35);
      chk("lat_count", 64'(n_commit - n0), 64'd1);
      chk("lat_count32", 64'(n_commit32 - n0_32), 64'd1);
      chk("lat_ch", 64'(last_ch), 64'd0);
      chk("lat_ch32", 64'(last_ch32), 64'd0);
      chk("busy_load", 64'(busy_k2), 64'd1);
      settle("lat");
      check_sb();

      // ch2: 0xFFFF ms fits 35 bits, saturates 32 bits
      push(1, 64'd6553500000, 3, 1'b0, 1'b0, 64'hFFFF_FFFF, 1'b1);
      wr_rec(1, 8'd0, 8'd1, 16'h0003, 8'd3, 16'hFFFF);
      settle("ch1_sat");
      check_sb();
      push(1, 100000, 3, 1'b0, 1'b0, 100000, 1'b0);
      wr(103, 8'h00); wr(104, 8'h01); wr_done();
      settle("ch1_clr");
      check_sb();

      // ch3: invalid unit code keeps duration, type still commits
      push(2, 42, 7, 1'b1, 1'b0, 42, 1'b0);
      wr_rec(2, 8'd1, 8'd1, 16'h0007, 8'd1, 16'h002A);
      settle("ch2_a");
      check_sb();
      push(2, 42, 7, 1'b0, 1'b0, 42, 1'b0);
      wr(95, 8'd7); wr(91, 8'd0); wr_done();
      settle("ch2_b");
      check_sb();

      // ch4: unit code 4
      push(3, 3, 1, 1'b0, 1'b0, 3, 1'b0);
      wr_rec(3, 8'd0, 8'd1, 16'h0001, 8'd1, 16'h0003);
      settle("ch3_a");
      check_sb();
`ifdef CFG_SEC_UNIT_EN
      sec_exp = 300000000;
`else
      sec_exp = 3;
`endif
      push(3, sec_exp, 1, 1'b0, 1'b0, sec_exp, 1'b0);
      wr(88, 8'd4); wr_done();
      settle("ch3_sec");
      check_sb();

      // Fairness: ch1 dirty while ch5 is hammered every cycle
      fair_base = n_commit; fair_ord = 0; fair_armed = 1'b1;
      push(0, 100, 500, 1'b1, 1'b0, 100, 1'b0);
      push(4, 64'h1234, 1600, 1'b1, 1'b0, 64'h1234, 1'b0);
      wr(105, 8'd1);
      for (int i = 0; i < 200; i++) begin
         wr(77 + (i % 7), (i >= 193) ? fin[i % 7] : 8'($urandom));
      end
      wr_done();
      settle("fair");
      fair_armed = 1'b0;
      chk("fair_ch0_by_second", 64'(fair_ord >= 1 && fair_ord <= 2), 64'd1);
      check_sb();

      // Reset during the delay multiply
      wr(105, 8'd0); wr_done();
      repeat (22) @(negedge clk);
      chk("mid_busy", 64'(busy35), 64'd1);
      rst = 1'b1;
      #1;
      chk("mrst_pl",    64'(PL35 == '0), 64'd1);
      chk("mrst_dl",    64'(DL35 == '0), 64'd1);
      chk("mrst_ts",    64'(ts35), 64'd0);
      chk("mrst_ovf",   64'(ovf35), 64'd0);
      chk("mrst_busy",  64'(busy35), 64'd0);
      chk("mrst_busy32", 64'(busy32), 64'd0);
      chk("mrst_stb",   64'(stb35), 64'd0);
      chk("mrst_pl32",  64'(PL32 == '0), 64'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n0 = n_commit;
      repeat (60) @(negedge clk);
      chk("post_rst_no_commit", 64'(n_commit - n0), 64'd0);
      rd_addr = 8'd110; @(negedge clk);
      chk("post_rst_mem", 64'(rd35), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
